cam_pixel_tx: RTL and testbench
===============================

CAM_PIXEL_TX -- requirements
Module: cam_pixel_tx

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- H_ACTIVE, 640, pixels per line
- V_ACTIVE, 480, lines per frame
- VSYNC_CYC, 1568, vsync-high cycles
- VBACK_CYC, 17, cycles from vsync fall to first href
- HBLANK_CYC, 288, href-low cycles between lines
- VFRONT_CYC, 10, cycles from last href fall to vsync rise
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- p_clock, in, 1, pixel clock (the only clock)
- rst_n, in, 1, reset (synchronous, active-low)
- enable, in, 1, start/continue frames
- pix_data, in, 16, RGB565 pixel from the source
- pix_valid, in, 1, pix_data valid
- pix_ready, out, 1, pixel accepted this cycle if pix_valid
- vsync, out, 1, frame sync (active high)
- href, out, 1, line valid (active high)
- p_data, out, 8, byte stream
- frame_start, out, 1, one-cycle pulse on the first href cycle of a frame
- underrun, out, 1, sticky flag: a pixel was needed and not supplied
- underrun_clr, in, 1, clears underrun
REQ-003 The block SHALL use one clock, p_clock; rst_n SHALL be synchronous and active-low.

Function
REQ-004 The FSM states SHALL be IDLE, VSYNC, VBACK, ACTIVE, HBLANK and VFRONT.
REQ-005 Transitions:
- IDLE->VSYNC when enable=1
- VSYNC->VBACK after VSYNC_CYC cycles
- VBACK->ACTIVE after VBACK_CYC cycles
- ACTIVE->HBLANK after 2*H_ACTIVE cycles, or ->VFRONT if the line was line V_ACTIVE-1
- HBLANK->ACTIVE after HBLANK_CYC cycles
- VFRONT->VSYNC if enable=1, else ->IDLE, after VFRONT_CYC cycles
REQ-006 vsync SHALL be 1 exactly in VSYNC; href SHALL be 1 exactly in ACTIVE; all outputs SHALL be registered.
REQ-007 Each pixel SHALL occupy two consecutive href cycles: pix_data[15:8] first, then pix_data[7:0].
REQ-008 p_data SHALL be 0x00 whenever href=0.
REQ-009 pix_ready SHALL be 1 only in the cycle immediately before a high-byte cycle (last VBACK cycle, last HBLANK cycle, or a low-byte cycle that is not a line's last); it SHALL be 0 in IDLE, VSYNC and VFRONT.
REQ-010 A pixel SHALL be accepted when pix_valid & pix_ready. Its high byte SHALL appear on p_data the next cycle and its low byte the cycle after.
REQ-011 If pix_ready=1 and pix_valid=0, the block SHALL emit 0x00,0x00 for that pixel, set underrun=1, and keep line and frame timing unchanged.
REQ-012 underrun_clr SHALL clear underrun; a simultaneous new underrun SHALL win (underrun stays 1).
REQ-013 Deasserting enable mid-frame SHALL NOT truncate the frame; the FSM SHALL finish through VFRONT, then go to IDLE.
REQ-014 Counters SHALL be $clog2-sized from the parameters, and line/pixel counts SHALL wrap to 0 at frame end.

Reset
REQ-015 With rst_n=0 at a p_clock edge, the following SHALL be 0 on the next cycle: state=IDLE, all counters, vsync, href, p_data, pix_ready, frame_start, underrun.
REQ-016 Reset mid-line SHALL abandon the frame; the held low byte SHALL be discarded.

Structure
REQ-017 Package cam_pkg SHALL hold the FSM state enum and the default geometry constants.
REQ-018 Timing generation (FSM, counters) SHALL live in sub-module cam_tx_timing; the byte mux, pixel hold register and underrun logic SHALL live in the top.

Verification (H_ACTIVE=4, V_ACTIVE=2, VSYNC_CYC=3, VBACK_CYC=2, HBLANK_CYC=3, VFRONT_CYC=2)
REQ-019 Hold rst_n=0 for 2 cycles -> every output is 0 and pix_ready stays 0 with enable=1 held low-reset.
REQ-020 enable=1, continuous valid pixels 0x1234, 0x5678, ... ->
- vsync high for 3 cycles, then 2 low before href
- href high 8 cycles per line
- p_data=12,34,56,78,...
- frame_start pulses once per frame
REQ-021 Drop pix_valid for the 2nd pixel of line 0 -> p_data=00,00 in cycles 3-4 of href, underrun=1, href still 8 cycles.
REQ-022 Drop enable during line 0 -> line 1 and VFRONT complete, then IDLE with vsync staying 0.
REQ-023 Pulse rst_n=0 at href cycle 5 -> next cycle href=0, p_data=0x00, state=IDLE; restart after reset produces a clean frame.
REQ-024 Loop back into the team's DVP capture block with pixels 0xA5C3.. -> 8 pixel_valid pulses per frame with data matching the sent pixels.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared types and default geometry for the camera pixel transmitter.
package cam_pkg;

   // Video timing FSM states
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_VSYNC  = 3'd1,
      ST_VBACK  = 3'd2,
      ST_ACTIVE = 3'd3,
      ST_HBLANK = 3'd4,
      ST_VFRONT = 3'd5
   } cam_state_e;

   // Default geometry (VGA-like frame)
   localparam int unsigned DEF_H_ACTIVE   = 640;
   localparam int unsigned DEF_V_ACTIVE   = 480;
   localparam int unsigned DEF_VSYNC_CYC  = 1568;
   localparam int unsigned DEF_VBACK_CYC  = 17;
   localparam int unsigned DEF_HBLANK_CYC = 288;
   localparam int unsigned DEF_VFRONT_CYC = 10;

   // Data path widths
   localparam int unsigned PIX_W  = 16;
   localparam int unsigned BYTE_W = 8;

   // Larger of two unsigned values, for sizing shared counters
   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   // Counter width able to hold 0..v-1, never narrower than one bit
   function automatic int unsigned clog2_min1(input int unsigned v);
      return (v <= 1) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/cam_tx_timing.sv
// Frame/line timing generator: FSM, cycle and line counters, registered sync strobes.
module cam_tx_timing
   import cam_pkg::*;
#(
   parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
   parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
   parameter int unsigned VSYNC_CYC  = DEF_VSYNC_CYC,
   parameter int unsigned VBACK_CYC  = DEF_VBACK_CYC,
   parameter int unsigned HBLANK_CYC = DEF_HBLANK_CYC,
   parameter int unsigned VFRONT_CYC = DEF_VFRONT_CYC
) (
   input  logic p_clock,
   input  logic rst_n,
   input  logic enable,
   output logic vsync,
   output logic href,
   output logic pix_ready,
   output logic frame_start
);

   localparam int unsigned LINE_BYTES = 2 * H_ACTIVE;
   localparam int unsigned CNT_MAX    = max_u(max_u(max_u(VSYNC_CYC, VBACK_CYC),
                                                    max_u(LINE_BYTES, HBLANK_CYC)),
                                              VFRONT_CYC);
   localparam int unsigned CNT_W      = clog2_min1(CNT_MAX);
   localparam int unsigned LINE_W     = clog2_min1(V_ACTIVE);

   localparam logic [CNT_W-1:0]  VSYNC_LAST  = CNT_W'(VSYNC_CYC - 1);
   localparam logic [CNT_W-1:0]  VBACK_LAST  = CNT_W'(VBACK_CYC - 1);
   localparam logic [CNT_W-1:0]  BYTE_LAST   = CNT_W'(LINE_BYTES - 1);
   localparam logic [CNT_W-1:0]  HBLANK_LAST = CNT_W'(HBLANK_CYC - 1);
   localparam logic [CNT_W-1:0]  VFRONT_LAST = CNT_W'(VFRONT_CYC - 1);
   localparam logic [LINE_W-1:0] LINE_LAST   = LINE_W'(V_ACTIVE - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
   localparam logic [LINE_W-1:0] LINE_ONE    = LINE_W'(1);

   cam_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [LINE_W-1:0] line_q, line_d;
   logic              vsync_q, vsync_d;
   logic              href_q, href_d;
   logic              pix_ready_q, pix_ready_d;
   logic              frame_start_q, frame_start_d;

   // Next-state and counter update; cnt is the in-state cycle (byte) count
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      line_d  = line_q;
      case (state_q)
         ST_IDLE: begin
            cnt_d  = '0;
            line_d = '0;
            if (enable) state_d = ST_VSYNC;
         end
         ST_VSYNC: begin
            if (cnt_q == VSYNC_LAST) begin
               state_d = ST_VBACK;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_VBACK: begin
            if (cnt_q == VBACK_LAST) begin
               state_d = ST_ACTIVE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_ACTIVE: begin
            if (cnt_q == BYTE_LAST) begin
               cnt_d = '0;
               if (line_q == LINE_LAST) begin
                  state_d = ST_VFRONT;
                  line_d  = '0;
               end else begin
                  state_d = ST_HBLANK;
                  line_d  = line_q + LINE_ONE;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_HBLANK: begin
            if (cnt_q == HBLANK_LAST) begin
               state_d = ST_ACTIVE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_VFRONT: begin
            if (cnt_q == VFRONT_LAST) begin
               state_d = enable ? ST_VSYNC : ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            line_d  = '0;
         end
      endcase
   end

   // Strobes decoded from the upcoming state so they line up with it once registered
   always_comb begin
      vsync_d       = (state_d == ST_VSYNC);
      href_d        = (state_d == ST_ACTIVE);
      frame_start_d = (state_q == ST_VBACK) && (state_d == ST_ACTIVE);
      // Request a pixel in the cycle just before every high-byte cycle
      pix_ready_d   = ((state_d == ST_VBACK)  && (cnt_d == VBACK_LAST))  ||
                      ((state_d == ST_HBLANK) && (cnt_d == HBLANK_LAST)) ||
                      ((state_d == ST_ACTIVE) && cnt_d[0] && (cnt_d != BYTE_LAST));
   end

   // State, counters and strobe registers with synchronous reset
   always_ff @(posedge p_clock) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         line_q        <= '0;
         vsync_q       <= 1'b0;
         href_q        <= 1'b0;
         pix_ready_q   <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         line_q        <= line_d;
         vsync_q       <= vsync_d;
         href_q        <= href_d;
         pix_ready_q   <= pix_ready_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign vsync       = vsync_q;
   assign href        = href_q;
   assign pix_ready   = pix_ready_q;
   assign frame_start = frame_start_q;

endmodule

// File: rtl/cam_pixel_tx.sv
// DVP-style camera transmitter: serialises RGB565 pixels as two bytes per href cycle pair.
module cam_pixel_tx
   import cam_pkg::*;
#(
   parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
   parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
   parameter int unsigned VSYNC_CYC  = DEF_VSYNC_CYC,
   parameter int unsigned VBACK_CYC  = DEF_VBACK_CYC,
   parameter int unsigned HBLANK_CYC = DEF_HBLANK_CYC,
   parameter int unsigned VFRONT_CYC = DEF_VFRONT_CYC
) (
   input  logic              p_clock,
   input  logic              rst_n,
   input  logic              enable,
   input  logic [PIX_W-1:0]  pix_data,
   input  logic              pix_valid,
   output logic              pix_ready,
   output logic              vsync,
   output logic              href,
   output logic [BYTE_W-1:0] p_data,
   output logic              frame_start,
   output logic              underrun,
   input  logic              underrun_clr
);

   logic              ready_c;
   logic              miss_c;
   logic [BYTE_W-1:0] p_data_q, p_data_d;
   logic [BYTE_W-1:0] lo_byte_q, lo_byte_d;
   logic              lo_pend_q, lo_pend_d;
   logic              underrun_q, underrun_d;

   cam_tx_timing #(
      .H_ACTIVE   (H_ACTIVE),
      .V_ACTIVE   (V_ACTIVE),
      .VSYNC_CYC  (VSYNC_CYC),
      .VBACK_CYC  (VBACK_CYC),
      .HBLANK_CYC (HBLANK_CYC),
      .VFRONT_CYC (VFRONT_CYC)
   ) u_timing (
      .p_clock     (p_clock),
      .rst_n       (rst_n),
      .enable      (enable),
      .vsync       (vsync),
      .href        (href),
      .pix_ready   (ready_c),
      .frame_start (frame_start)
   );

   // Byte mux and low-byte hold; a missing pixel is sent as zeros
   always_comb begin
      p_data_d  = '0;
      lo_byte_d = lo_byte_q;
      lo_pend_d = ready_c;
      miss_c    = ready_c & ~pix_valid;
      if (ready_c) begin
         p_data_d  = pix_valid ? pix_data[PIX_W-1:BYTE_W] : '0;
         lo_byte_d = pix_valid ? pix_data[BYTE_W-1:0]     : '0;
      end else if (lo_pend_q) begin
         p_data_d = lo_byte_q;
      end
   end

   // Sticky underrun; a fresh miss overrides a same-cycle clear
   always_comb begin
      underrun_d = underrun_q;
      if (underrun_clr) underrun_d = 1'b0;
      if (miss_c)       underrun_d = 1'b1;
   end

   // Output and hold registers; reset drops any pending low byte
   always_ff @(posedge p_clock) begin
      if (!rst_n) begin
         p_data_q   <= '0;
         lo_byte_q  <= '0;
         lo_pend_q  <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         p_data_q   <= p_data_d;
         lo_byte_q  <= lo_byte_d;
         lo_pend_q  <= lo_pend_d;
         underrun_q <= underrun_d;
      end
   end

   assign pix_ready = ready_c;
   assign p_data    = p_data_q;
   assign underrun  = underrun_q;

endmodule

// File: tb/tb_cam_pixel_tx.sv
// Bench for cam_pixel_tx: frame-position reference model plus directed and random phases.
module tb_cam_pixel_tx;

   localparam int H    = 4;
   localparam int V    = 2;
   localparam int VS   = 3;
   localparam int VB   = 2;
   localparam int HB   = 3;
   localparam int VF   = 2;
   localparam int LB   = 2 * H;
   localparam int PER  = LB + HB;
   localparam int LACT = V * LB + (V - 1) * HB;
   localparam int FL   = VS + VB + LACT + VF;

   localparam int MODE_SEQ  = 0;
   localparam int MODE_DROP = 1;
   localparam int MODE_RAND = 2;
   localparam int MODE_LOOP = 3;

   logic        p_clock;
   logic        rst_n;
   logic        enable;
   logic [15:0] pix_data;
   logic        pix_valid;
   logic        pix_ready;
   logic        vsync;
   logic        href;
   logic [7:0]  p_data;
   logic        frame_start;
   logic        underrun;
   logic        underrun_clr;

   cam_pixel_tx #(
      .H_ACTIVE   (H),
      .V_ACTIVE   (V),
      .VSYNC_CYC  (VS),
      .VBACK_CYC  (VB),
      .HBLANK_CYC (HB),
      .VFRONT_CYC (VF)
   ) dut (
      .p_clock      (p_clock),
      .rst_n        (rst_n),
      .enable       (enable),
      .pix_data     (pix_data),
      .pix_valid    (pix_valid),
      .pix_ready    (pix_ready),
      .vsync        (vsync),
      .href         (href),
      .p_data       (p_data),
      .frame_start  (frame_start),
      .underrun     (underrun),
      .underrun_clr (underrun_clr)
   );

   initial p_clock = 1'b0;
   always #5 p_clock = ~p_clock;

   // Reference model: either idle, or at position m_pos within a frame
   bit          m_in;
   int          m_pos;
   bit          m_under;
   logic [15:0] m_pix;

   int          n_checks;
   int          n_fail;
   int          cyc;
   int          mode;
   int          src_idx;
   bit          clr_req;
   bit          edge_rst;
   int          hr_run;
   logic [7:0]  lb_hi;
   int          lb_k;
   bit          lb_on;
   int          fs_seen;

   function automatic bit is_act(input int p, output int line, output int b);
      int o;
      o    = p - VS - VB;
      line = 0;
      b    = 0;
      if (o < 0 || o >= LACT) return 1'b0;
      line = o / PER;
      b    = o % PER;
      return b < LB;
   endfunction

   // A pixel is requested when the next frame position is a high byte
   function automatic bit exp_ready(input bit in_f, input int p);
      int l, b;
      if (!in_f || p + 1 >= FL) return 1'b0;
      if (!is_act(p + 1, l, b)) return 1'b0;
      return (b % 2) == 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, expv, cyc);
      end
   endtask

   // One clock: advance the model with the sampled inputs, then compare all outputs
   task automatic step();
      bit   rdy, ev, eh, efs, er;
      int   l, b;
      logic [7:0] epd;
      rdy = exp_ready(m_in, m_pos);
      @(posedge p_clock);
      edge_rst = !rst_n;
      if (!rst_n) begin
         m_in    = 1'b0;
         m_pos   = 0;
         m_under = 1'b0;
         m_pix   = 16'h0;
      end else begin
         if (rdy) begin
            m_pix = pix_valid ? pix_data : 16'h0;
            if (pix_valid) src_idx++;
            if (!pix_valid)        m_under = 1'b1;
            else if (underrun_clr) m_under = 1'b0;
         end else if (underrun_clr) begin
            m_under = 1'b0;
         end
         if (!m_in) begin
            if (enable) begin m_in = 1'b1; m_pos = 0; end
         end else if (m_pos == FL - 1) begin
            if (enable) m_pos = 0;
            else        m_in  = 1'b0;
         end else begin
            m_pos++;
         end
      end
      #1;
      cyc++;
      ev  = m_in && (m_pos < VS);
      eh  = m_in && is_act(m_pos, l, b);
      efs = eh && (l == 0) && (b == 0);
      er  = exp_ready(m_in, m_pos);
      epd = !eh ? 8'h00 : ((b % 2 == 0) ? m_pix[15:8] : m_pix[7:0]);
      chk("vsync",       32'(vsync),       32'(ev));
      chk("href",        32'(href),        32'(eh));
      chk("frame_start", 32'(frame_start), 32'(efs));
      chk("pix_ready",   32'(pix_ready),   32'(er));
      chk("p_data",      32'(p_data),      32'(epd));
      chk("underrun",    32'(underrun),    32'(m_under));
      if (frame_start) fs_seen++;
      if (href) begin
         if (lb_on) begin
            if (hr_run % 2 == 0) begin
               lb_hi = p_data;
            end else begin
               chk("loop_pix", 32'({lb_hi, p_data}), 32'(16'hA5C3 + 16'(lb_k) * 16'h0101));
               lb_k++;
            end
         end
         hr_run++;
      end else begin
         if (hr_run != 0 && !edge_rst) chk("href_len", 32'(hr_run), 32'(LB));
         hr_run = 0;
      end
   endtask

   // Present the next pixel/valid/clear according to the current mode
   task automatic drive();
      int l, b;
      bit r;
      r = exp_ready(m_in, m_pos);
      underrun_clr = clr_req;
      pix_valid    = 1'b1;
      case (mode)
         MODE_DROP: begin
            pix_data = 16'h1234 + 16'(src_idx) * 16'h4444;
            if (r && is_act(m_pos + 1, l, b) && l == 0 && b == 2) begin
               pix_valid    = 1'b0;
               underrun_clr = 1'b1;
            end
         end
         MODE_RAND: begin
            pix_data     = 16'($urandom);
            pix_valid    = ($urandom_range(0, 3) != 0);
            underrun_clr = ($urandom_range(0, 7) == 0);
            enable       = ($urandom_range(0, 15) != 0);
         end
         MODE_LOOP: pix_data = 16'hA5C3 + 16'(src_idx) * 16'h0101;
         default:   pix_data = 16'h1234 + 16'(src_idx) * 16'h4444;
      endcase
   endtask

   task automatic run(input int n);
      repeat (n) begin
         drive();
         step();
      end
   endtask

   task automatic run_until_pos(input int tgt, input int maxc, input string tag);
      int k;
      k = 0;
      while (!(m_in && m_pos == tgt) && k < maxc) begin
         drive();
         step();
         k++;
      end
      chk(tag, 32'(m_in && m_pos == tgt), 32'd1);
   endtask

   task automatic run_until_idle(input int maxc, input string tag);
      int k;
      k = 0;
      while (m_in && k < maxc) begin
         drive();
         step();
         k++;
      end
      chk(tag, 32'(m_in), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0; n_fail = 0; cyc = 0; mode = MODE_SEQ; src_idx = 0;
      clr_req = 1'b0; edge_rst = 1'b0; hr_run = 0; lb_hi = 8'h0; lb_k = 0;
      lb_on = 1'b0; fs_seen = 0;
      m_in = 1'b0; m_pos = 0; m_under = 1'b0; m_pix = 16'h0;
      rst_n = 1'b0; enable = 1'b1; pix_data = 16'h0; pix_valid = 1'b1;
      underrun_clr = 1'b0;

      // Reset held with enable high: everything stays zero
      repeat (2) step();
      chk("rst_pix_ready", 32'(pix_ready), 32'd0);
      chk("rst_p_data",    32'(p_data),    32'd0);

      // Two frames of continuous pixels 0x1234, 0x5678, ...
      rst_n = 1'b1;
      src_idx = 0;
      fs_seen = 0;
      run(1 + 2 * FL);
      chk("frame_start_count", 32'(fs_seen), 32'd2);

      // Missing second pixel of line 0, with a coincident clear request
      mode = MODE_DROP;
      run(FL);
      chk("underrun_set", 32'(underrun), 32'd1);
      mode = MODE_SEQ;
      clr_req = 1'b1;
      run(1);
      clr_req = 1'b0;
      chk("underrun_cleared", 32'(underrun), 32'd0);

      // Random valid/data/clear/enable traffic
      mode = MODE_RAND;
      run(300);
      mode = MODE_SEQ;
      enable = 1'b1;
      underrun_clr = 1'b0;

      // Enable dropped during line 0: frame completes, then idle
      run_until_pos(VS + VB + 1, 3 * FL, "reach_line0");
      enable = 1'b0;
      run_until_idle(2 * FL, "reach_idle");
      repeat (10) begin
         run(1);
         chk("idle_vsync", 32'(vsync), 32'd0);
      end

      // Reset at the fifth href cycle, then a clean restart
      enable = 1'b1;
      run_until_pos(VS + VB + 4, 3 * FL, "reach_href5");
      rst_n = 1'b0;
      step();
      chk("rst_mid_href",   32'(href),   32'd0);
      chk("rst_mid_p_data", 32'(p_data), 32'd0);
      rst_n = 1'b1;
      fs_seen = 0;
      run(1 + FL);
      chk("restart_frame_start", 32'(fs_seen), 32'd1);

      // Loop-back capture of two frames of 0xA5C3, 0xA6C4, ...
      enable = 1'b0;
      run_until_idle(2 * FL, "idle_before_loop");
      mode = MODE_LOOP;
      src_idx = 0;
      lb_k = 0;
      lb_on = 1'b1;
      fs_seen = 0;
      enable = 1'b1;
      for (int k = 0; k < 5 * FL && fs_seen < 2; k++) run(1);
      enable = 1'b0;
      run_until_idle(2 * FL, "loop_idle");
      lb_on = 1'b0;
      chk("loop_pixel_count", 32'(lb_k), 32'(2 * H * V));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
